// File: rtl/adder_pkg.sv
// Shared constants and a behavioural reference sum for the adders library.
// The reference is a plain integer add, kept independent of the ripple-carry netlist.
package adder_pkg;

  localparam int ADDER_MAX_WIDTH = 64;

  // Returns {carry, sum} of a width-bit add; bits above 'width' are zero.
  function automatic logic [ADDER_MAX_WIDTH:0] adder_ref(
    input int unsigned                  width,
    input logic [ADDER_MAX_WIDTH-1:0]   a,
    input logic [ADDER_MAX_WIDTH-1:0]   b,
    input logic                         ci
  );
    logic [ADDER_MAX_WIDTH:0] mask;
    logic [ADDER_MAX_WIDTH:0] full;
    mask = '0;
    for (int i = 0; i < ADDER_MAX_WIDTH; i++) begin
      if (i < int'(width)) mask[i] = 1'b1;
    end
    full = {1'b0, a & mask[ADDER_MAX_WIDTH-1:0]} + {1'b0, b & mask[ADDER_MAX_WIDTH-1:0]}
         + {{ADDER_MAX_WIDTH{1'b0}}, ci};
    mask = (mask << 1) | {{ADDER_MAX_WIDTH{1'b0}}, 1'b1};
    return full & mask;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell, purely combinational.
// Latency: 0 cycles. Backpressure: none.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder {C_out,S} = A+B+C_in; FULL_ADDER_OVFL_EN adds signed overflow OVFL.
// Latency: 1 cycle. Backpressure: none, accepts one operand set per cycle.
module full_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
`ifdef FULL_ADDER_OVFL_EN
  output logic             OVFL,
`endif
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_width_check
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = C_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Result registers load only on in_valid, so undriven operands never reach S.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      S         <= '0;
      C_out     <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_ADDER_OVFL_EN
      OVFL      <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        S     <= sum;
        C_out <= c[WIDTH];
`ifdef FULL_ADDER_OVFL_EN
        OVFL  <= c[WIDTH] ^ c[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=8; OVFL checked when FULL_ADDER_OVFL_EN is defined.
module tb_full_adder;
  import adder_pkg::*;

  logic       clk;
  logic       rst_n;

  logic       iv1, a1, b1, c1;
  logic       s1, co1, ov_vld1;
  logic       iv8, c8;
  logic [7:0] a8, b8, s8;
  logic       co8, ov_vld8;
`ifdef FULL_ADDER_OVFL_EN
  logic       ovfl1, ovfl8;
`endif

  int n_checks;
  int n_fail;

  logic [ADDER_MAX_WIDTH:0] sb8[$];
  logic [1:0]               sb1[$];

  typedef struct {
    logic       a, b, ci;
    logic [1:0] exp;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] exp_s;
    logic       exp_co;
    logic       exp_ov;
  } vec8_t;

  vec1_t v1[9];
  vec8_t v8[6];

  full_adder #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .RST_n(rst_n), .in_valid(iv1), .A(a1), .B(b1), .C_in(c1),
    .S(s1), .C_out(co1),
`ifdef FULL_ADDER_OVFL_EN
    .OVFL(ovfl1),
`endif
    .out_valid(ov_vld1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST_n(rst_n), .in_valid(iv8), .A(a8), .B(b8), .C_in(c8),
    .S(s8), .C_out(co8),
`ifdef FULL_ADDER_OVFL_EN
    .OVFL(ovfl8),
`endif
    .out_valid(ov_vld8)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic a, input logic b, input logic ci, input logic [1:0] exp);
    @(negedge clk);
    iv1 = 1'b1; a1 = a; b1 = b; c1 = ci;
    sb1.push_back(exp);
  endtask

  task automatic pop1(input string name);
    logic [1:0] exp;
    @(posedge clk); #1;
    check({name, " out_valid"}, 64'(ov_vld1), 64'd1);
    if (sb1.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb1.pop_front();
      check({name, " {C_out,S}"}, 64'({co1, s1}), 64'(exp));
    end
  endtask

  task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    iv8 = 1'b1; a8 = a; b8 = b; c8 = ci;
    sb8.push_back(adder_ref(8, {56'd0, a}, {56'd0, b}, ci));
  endtask

  task automatic pop8(input string name);
    logic [ADDER_MAX_WIDTH:0] exp;
    @(posedge clk); #1;
    check({name, " out_valid"}, 64'(ov_vld8), 64'd1);
    if (sb8.size() == 0) begin
      check({name, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb8.pop_front();
      check({name, " {C_out,S}"}, 64'({co8, s8}), 64'(exp[8:0]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    v1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    v1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    v1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    v1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    v1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    v1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    v1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    v1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};
    v1[8] = '{1'b0, 1'b0, 1'b0, 2'b00};

    v8[0] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    v8[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    v8[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    v8[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    v8[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    v8[5] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};

    rst_n = 1'b0;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    #1;
    check("reset w1 {out_valid,C_out,S}", 64'({ov_vld1, co1, s1}), 64'd0);
    check("reset w8 {out_valid,C_out,S}", 64'({ov_vld8, co8, s8}), 64'd0);
`ifdef FULL_ADDER_OVFL_EN
    check("reset OVFL", 64'({ovfl1, ovfl8}), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive table
    for (int i = 0; i < 9; i++) begin
      push1(v1[i].a, v1[i].b, v1[i].ci, v1[i].exp);
      pop1($sformatf("w1 vec%0d", i));
    end

    // Asynchronous reset mid-stream after 1+1+1 was captured
    push1(1'b1, 1'b1, 1'b1, 2'b11);
    pop1("w1 pre-reset 1+1+1");
    @(negedge clk);
    iv1 = 1'b0;
    #10 rst_n = 1'b0;
    #1;
    check("async reset w1 {out_valid,C_out,S}", 64'({ov_vld1, co1, s1}), 64'd0);
    @(posedge clk); #1;
    check("reset held w1 {out_valid,C_out,S}", 64'({ov_vld1, co1, s1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk); #1;
    check("post-release idle w1 {out_valid,C_out,S}", 64'({ov_vld1, co1, s1}), 64'd0);

    // Hold: capture 1+0+1, then idle with zero operands
    push1(1'b1, 1'b0, 1'b1, 2'b10);
    pop1("w1 hold capture");
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk); #1;
    check("hold w1 {C_out,S}", 64'({co1, s1}), 64'h2);
    check("hold w1 out_valid", 64'(ov_vld1), 64'd0);

    // WIDTH=8 boundary and overflow table
    for (int i = 0; i < 6; i++) begin
      push8(v8[i].a, v8[i].b, v8[i].ci);
      @(posedge clk); #1;
      check($sformatf("w8 vec%0d out_valid", i), 64'(ov_vld8), 64'd1);
      check($sformatf("w8 vec%0d S", i), 64'(s8), 64'(v8[i].exp_s));
      check($sformatf("w8 vec%0d C_out", i), 64'(co8), 64'(v8[i].exp_co));
`ifdef FULL_ADDER_OVFL_EN
      check($sformatf("w8 vec%0d OVFL", i), 64'(ovfl8), 64'(v8[i].exp_ov));
`endif
      void'(sb8.pop_front());
    end

    // Idle with changing operands: registers hold 0x10+0x20 result
    @(negedge clk);
    iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    @(posedge clk); #1;
    check("hold w8 {C_out,S}", 64'({co8, s8}), 64'h030);
    check("hold w8 out_valid", 64'(ov_vld8), 64'd0);

    // Back-to-back random operands against the package reference
    for (int i = 0; i < 16; i++) begin
      push8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      pop8($sformatf("w8 b2b%0d", i));
    end
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk); #1;
    check("w8 b2b drain out_valid", 64'(ov_vld8), 64'd0);
    check("w8 scoreboard drained", 64'(sb8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
